// File: rtl/fir_mc_pkg.sv
// Shared types and arithmetic helpers for the multi-channel FIR.
// State encoding, width derivations and output rounding/saturation.
package fir_mc_pkg;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WRITE = 3'd1,
    S_MAC   = 3'd2,
    S_DRAIN = 3'd3,
    S_OUT   = 3'd4
  } state_t;

  function automatic int ptr_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  function automatic int acc_width(
    input int dw,
    input int cw,
    input int depth
  );
    return dw + cw + $clog2(depth);
  endfunction

  // Round half up, arithmetic shift, clamp to a dw-bit signed range.
  function automatic logic signed [63:0] sat_round(
    input logic signed [127:0] acc,
    input int                  shift,
    input int                  dw
  );
    logic signed [127:0] r;
    logic signed [127:0] lim;
    r   = (acc + (128'sd1 <<< (shift - 1))) >>> shift;
    lim = 128'sd1 <<< (dw - 1);
    if (r > lim - 128'sd1) begin
      return 64'(lim - 128'sd1);
    end else if (r < -lim) begin
      return 64'(-lim);
    end
    return 64'(r);
  endfunction

endpackage

// File: rtl/fir_mac_pipe.sv
// Two-stage signed multiply-accumulate: registered product,
// then accumulate. Clear has priority over accumulation.
module fir_mac_pipe #(
  parameter int DATA_WIDTH = 24,
  parameter int COEF_WIDTH = 18,
  parameter int ACC_WIDTH  = 46
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         i_clr,
  input  logic                         i_en,
  input  logic signed [DATA_WIDTH-1:0] iv_a,
  input  logic signed [COEF_WIDTH-1:0] iv_b,
  output logic signed [ACC_WIDTH-1:0]  ov_acc
);

  localparam int PW = DATA_WIDTH + COEF_WIDTH;

  logic signed [PW-1:0]        prod;
  logic                        prod_vld;
  logic signed [ACC_WIDTH-1:0] acc;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      prod     <= '0;
      prod_vld <= 1'b0;
      acc      <= '0;
    end else begin
      prod     <= iv_a * iv_b;
      prod_vld <= i_en;
      if (i_clr) begin
        acc <= '0;
      end else if (prod_vld) begin
        acc <= acc + ACC_WIDTH'(prod);
      end
    end
  end

  assign ov_acc = acc;

endmodule

// File: rtl/fir_filter_mc.sv
// Time-multiplexed multi-channel FIR: one MAC shared by all
// channels, per-channel circular history, loadable taps.
module fir_filter_mc
  import fir_mc_pkg::*;
#(
  parameter int DATA_WIDTH = 24,
  parameter int COEF_WIDTH = 18,
  parameter int FIR_DEPTH  = 16,
  parameter int NUM_CH     = 4,
  parameter int OUT_SHIFT  = 15
) (
  input  logic                                 i_clk,
  input  logic                                 i_rst,
  input  logic signed [DATA_WIDTH-1:0]         iv_din,
  input  logic [ptr_width(NUM_CH)-1:0]         iv_din_ch,
  input  logic                                 i_din_valid,
  output logic                                 o_din_ready,
  output logic signed [DATA_WIDTH-1:0]         ov_dout,
  output logic [ptr_width(NUM_CH)-1:0]         ov_dout_ch,
  output logic                                 o_dout_valid,
  input  logic                                 i_dout_ready,
  input  logic                                 i_coef_we,
  input  logic [ptr_width(FIR_DEPTH)-1:0]      iv_coef_addr,
  input  logic signed [COEF_WIDTH-1:0]         iv_coef_data,
  output logic                                 o_busy
);

  localparam int AW    = ptr_width(FIR_DEPTH);
  localparam int CHW   = ptr_width(NUM_CH);
  localparam int ACC_W = acc_width(DATA_WIDTH, COEF_WIDTH, FIR_DEPTH);
  localparam logic signed [COEF_WIDTH-1:0] COEF_ONE =
    COEF_WIDTH'(64'd1 << OUT_SHIFT);

  state_t state;
  state_t state_nx;

  logic signed [DATA_WIDTH-1:0] hist [NUM_CH][FIR_DEPTH];
  logic signed [COEF_WIDTH-1:0] coef [FIR_DEPTH];
  logic [AW-1:0]                wr_ptr [NUM_CH];

  logic signed [DATA_WIDTH-1:0] din_q;
  logic [CHW-1:0]               ch_q;
  logic [AW-1:0]                base;
  logic [AW-1:0]                tap;
  logic                         drain_cnt;
  logic                         din_ready_q;
  logic                         dout_valid_q;
  logic signed [DATA_WIDTH-1:0] dout_q;
  logic [CHW-1:0]               dout_ch_q;

  logic                         in_xfer;
  logic                         out_xfer;
  logic                         coef_wr;
  logic [AW-1:0]                rd_addr;
  logic signed [ACC_W-1:0]      acc;

  assign in_xfer  = (state == S_IDLE) && i_din_valid && din_ready_q;
  assign out_xfer = (state == S_OUT) && dout_valid_q && i_dout_ready;
  assign coef_wr  = (state == S_IDLE) && i_coef_we && !in_xfer;
  assign rd_addr  = base + tap;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      S_IDLE:  if (in_xfer) state_nx = S_WRITE;
      S_WRITE: state_nx = S_MAC;
      S_MAC:   if (tap == AW'(FIR_DEPTH - 1)) state_nx = S_DRAIN;
      S_DRAIN: if (drain_cnt) state_nx = S_OUT;
      S_OUT:   if (out_xfer) state_nx = S_IDLE;
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      din_q        <= '0;
      ch_q         <= '0;
      base         <= '0;
      tap          <= '0;
      drain_cnt    <= 1'b0;
      din_ready_q  <= 1'b1;
      dout_valid_q <= 1'b0;
      dout_q       <= '0;
      dout_ch_q    <= '0;
    end else begin
      if (in_xfer) begin
        din_q       <= iv_din;
        ch_q        <= iv_din_ch;
        din_ready_q <= 1'b0;
      end
      unique case (state)
        S_WRITE: begin
          base <= wr_ptr[ch_q];
          tap  <= '0;
        end
        S_MAC: begin
          tap       <= tap + AW'(1);
          drain_cnt <= 1'b0;
        end
        S_DRAIN: drain_cnt <= ~drain_cnt;
        S_OUT: begin
          // First OUT cycle registers the result; later ones wait.
          if (!dout_valid_q) begin
            dout_valid_q <= 1'b1;
            dout_ch_q    <= ch_q;
            dout_q       <= DATA_WIDTH'(sat_round(
              {{(128 - ACC_W){acc[ACC_W-1]}}, acc},
              OUT_SHIFT, DATA_WIDTH));
          end else if (i_dout_ready) begin
            dout_valid_q <= 1'b0;
            din_ready_q  <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        wr_ptr[c] <= '0;
        for (int t = 0; t < FIR_DEPTH; t++) begin
          hist[c][t] <= '0;
        end
      end
      for (int t = 0; t < FIR_DEPTH; t++) begin
        coef[t] <= (t == 0) ? COEF_ONE : '0;
      end
    end else begin
      if (state == S_WRITE) begin
        hist[ch_q][wr_ptr[ch_q]] <= din_q;
        wr_ptr[ch_q]             <= wr_ptr[ch_q] - AW'(1);
      end
      if (coef_wr) begin
        coef[iv_coef_addr] <= iv_coef_data;
      end
    end
  end

  fir_mac_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .COEF_WIDTH (COEF_WIDTH),
    .ACC_WIDTH  (ACC_W)
  ) u_mac (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_clr  (state == S_WRITE),
    .i_en   (state == S_MAC),
    .iv_a   (hist[ch_q][rd_addr]),
    .iv_b   (coef[tap]),
    .ov_acc (acc)
  );

  assign o_din_ready  = din_ready_q;
  assign o_dout_valid = dout_valid_q;
  assign ov_dout      = dout_q;
  assign ov_dout_ch   = dout_ch_q;
  assign o_busy       = (state != S_IDLE);

endmodule

// File: tb/tb_fir_filter_mc.sv
// Scoreboard bench for fir_filter_mc against a queue-based
// convolution model of each channel.
module tb_fir_filter_mc;

  localparam int DW    = 24;
  localparam int CWID  = 18;
  localparam int DEPTH = 16;
  localparam int NCH   = 4;
  localparam int SH    = 15;
  localparam int CHW   = 2;
  localparam int AW    = 4;
  localparam int LAT   = DEPTH + 4;

  logic                   i_clk = 1'b0;
  logic                   i_rst = 1'b1;
  logic signed [DW-1:0]   iv_din = '0;
  logic [CHW-1:0]         iv_din_ch = '0;
  logic                   i_din_valid = 1'b0;
  logic                   o_din_ready;
  logic signed [DW-1:0]   ov_dout;
  logic [CHW-1:0]         ov_dout_ch;
  logic                   o_dout_valid;
  logic                   i_dout_ready = 1'b1;
  logic                   i_coef_we = 1'b0;
  logic [AW-1:0]          iv_coef_addr = '0;
  logic signed [CWID-1:0] iv_coef_data = '0;
  logic                   o_busy;

  fir_filter_mc dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .iv_din       (iv_din),
    .iv_din_ch    (iv_din_ch),
    .i_din_valid  (i_din_valid),
    .o_din_ready  (o_din_ready),
    .ov_dout      (ov_dout),
    .ov_dout_ch   (ov_dout_ch),
    .o_dout_valid (o_dout_valid),
    .i_dout_ready (i_dout_ready),
    .i_coef_we    (i_coef_we),
    .iv_coef_addr (iv_coef_addr),
    .iv_coef_data (iv_coef_data),
    .o_busy       (o_busy)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    int     ch;
    int     val;
    longint t;
  } exp_t;

  exp_t   sb[$];
  longint mcoef[DEPTH];
  int     mhist[NCH][$];
  int     checks = 0;
  int     errors = 0;
  longint cyc = 0;
  int     ready_mode = 0;

  always @(posedge i_clk) cyc <= cyc + 1;

  // 0: always ready, 1: stalled, 2: random
  always @(posedge i_clk) begin
    #1;
    case (ready_mode)
      1:       i_dout_ready = 1'b0;
      2:       i_dout_ready = ($urandom_range(0, 3) != 0);
      default: i_dout_ready = 1'b1;
    endcase
  end

  task automatic chk(input string nm, input longint act,
                     input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) mhist[c].delete();
    for (int k = 0; k < DEPTH; k++) mcoef[k] = 0;
    mcoef[0] = longint'(1) << SH;
  endfunction

  // y = sat(round(sum_k x[n-k] * c[k] / 2^SH))
  function automatic int model(input int ch, input int x);
    longint acc = 0;
    longint r;
    longint mx = (longint'(1) << (DW - 1)) - 1;
    longint mn = -(longint'(1) << (DW - 1));
    mhist[ch].push_front(x);
    if (mhist[ch].size() > DEPTH) void'(mhist[ch].pop_back());
    for (int k = 0; k < mhist[ch].size(); k++)
      acc += longint'(mhist[ch][k]) * mcoef[k];
    r = (acc + (longint'(1) << (SH - 1))) >>> SH;
    if (r > mx) r = mx;
    if (r < mn) r = mn;
    return int'(r);
  endfunction

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!o_din_ready && n < 2000) begin
      tick();
      n++;
    end
    if (n >= 2000) chk("din_ready_timeout", o_din_ready, 1);
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((o_busy || sb.size() != 0) && n < 4000) begin
      tick();
      n++;
    end
    if (n >= 4000) chk("idle_timeout", sb.size(), 0);
  endtask

  task automatic send(input int ch, input int x);
    wait_ready();
    iv_din      = DW'(x);
    iv_din_ch   = CHW'(ch);
    i_din_valid = 1'b1;
    tick();
    i_din_valid = 1'b0;
    sb.push_back('{ch, model(ch, x), cyc});
    chk("din_ready_drop", o_din_ready, 0);
  endtask

  task automatic wcoef(input int a, input int d);
    wait_idle();
    iv_coef_addr = AW'(a);
    iv_coef_data = CWID'(d);
    i_coef_we    = 1'b1;
    tick();
    i_coef_we    = 1'b0;
    mcoef[a]     = d;
  endtask

  logic   prev_v = 1'b0;
  longint held = 0;

  always @(negedge i_clk) begin
    exp_t e;
    if (o_dout_valid) begin
      if (!prev_v) begin
        held = ov_dout;
        if (sb.size() == 0) chk("unexpected_output", 1, 0);
        else chk("latency", cyc - sb[0].t, LAT);
      end
      chk("din_ready_in_out", o_din_ready, 0);
      if (i_dout_ready && sb.size() != 0) begin
        e = sb.pop_front();
        chk("dout", ov_dout, e.val);
        chk("dout_ch", ov_dout_ch, e.ch);
        chk("dout_stable", ov_dout, held);
      end
    end
    prev_v = o_dout_valid;
  end

  initial begin
    model_reset();
    repeat (3) tick();
    i_rst = 1'b0;
    chk("rst_din_ready", o_din_ready, 1);
    chk("rst_dout_valid", o_dout_valid, 0);
    chk("rst_dout", ov_dout, 0);
    chk("rst_dout_ch", ov_dout_ch, 0);
    chk("rst_busy", o_busy, 0);

    send(0, 1000);
    send(0, -5);
    send(0, 8388607);

    for (int k = 0; k < DEPTH; k++) wcoef(k, (k + 1) << 11);
    send(2, 16);
    for (int i = 0; i < DEPTH; i++) send(2, 0);

    send(1, 777);
    repeat (6) tick();
    i_rst = 1'b1;
    tick();
    i_rst = 1'b0;
    void'(sb.pop_back());
    model_reset();
    chk("abort_valid", o_dout_valid, 0);
    chk("abort_ready", o_din_ready, 1);
    chk("abort_busy", o_busy, 0);
    repeat (30) tick();
    send(3, -12345);

    for (int k = 0; k < DEPTH; k++) wcoef(k, 1 << 15);
    for (int i = 0; i < 4; i++) begin
      send(0, 100);
      send(1, -7);
    end

    for (int i = 0; i < DEPTH; i++) send(3, 8388607);
    for (int i = 0; i < DEPTH; i++) send(3, -8388608);

    for (int k = 0; k < DEPTH; k++) wcoef(k, 0);
    wcoef(0, 16384);
    send(2, 3);
    send(2, -3);

    wait_idle();
    ready_mode = 1;
    send(1, 4242);
    repeat (50 + LAT) tick();
    chk("bp_hold_valid", o_dout_valid, 1);
    chk("bp_hold_ready", o_din_ready, 0);
    ready_mode = 0;

    send(0, 10);
    repeat (3) tick();
    iv_coef_addr = AW'(0);
    iv_coef_data = CWID'(1000);
    i_coef_we    = 1'b1;
    tick();
    i_coef_we    = 1'b0;
    send(0, 11);

    wait_ready();
    iv_din       = DW'(20);
    iv_din_ch    = CHW'(3);
    iv_coef_addr = AW'(0);
    iv_coef_data = CWID'(5000);
    i_coef_we    = 1'b1;
    i_din_valid  = 1'b1;
    tick();
    i_din_valid  = 1'b0;
    i_coef_we    = 1'b0;
    sb.push_back('{3, model(3, 20), cyc});
    send(3, 21);

    for (int k = 0; k < DEPTH; k++)
      wcoef(k, int'($urandom_range(0, 40000)) - 20000);
    ready_mode = 2;
    for (int i = 0; i < 24; i++)
      send(int'($urandom_range(0, NCH - 1)),
           int'($urandom_range(0, 16777215)) - 8388608);
    wait_idle();
    ready_mode = 0;
    wait_idle();
    chk("sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
